rgb_hue_sequencer: RTL

//  Drives the on-board active-low RGB LED through a continuous colour wheel:
//  red -> yellow -> green -> cyan -> blue -> magenta -> red.
//  Per-channel PWM gives smooth linear crossfades between colours.

---
 rtl/rgb_pkg.sv | 21 ++
 rtl/rgb_pwm_channel.sv | 23 ++
 rtl/rgb_hue_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB hue sequencer.
// The LED pins are active-low, so LED_ON is 0 and LED_OFF is 1.
package rgb_pkg;

    typedef enum logic [2:0] {
        PH_RY = 3'd0,
        PH_YG = 3'd1,
        PH_GC = 3'd2,
        PH_CB = 3'd3,
        PH_BM = 3'd4,
        PH_MR = 3'd5
    } phase_t;

    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;

    function automatic phase_t next_phase(input phase_t p);
        return (p == PH_MR) ? PH_RY : phase_t'(p + 3'd1);
    endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM colour channel.
// The pin is registered and lit only while enabled and duty exceeds the shared counter.
module rgb_pwm_channel
    import rgb_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PWM_BITS-1:0] duty,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                pin
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            pin <= LED_OFF;
        else
            pin <= (en && (duty > pwm_cnt)) ? LED_ON : LED_OFF;
    end

endmodule

// File: rtl/rgb_hue_sequencer.sv
// Colour-wheel sequencer: prescaler, ramp, phase FSM and duty mux
// that feed three PWM channels driving the active-low RGB LED.
module rgb_hue_sequencer
    import rgb_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 7812
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       restart,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic [2:0] phase,
    output logic       phase_wrap
);

    localparam int                  PS_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(STEP_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] MAX     = '1;

    logic [PS_W-1:0]     ps_q;
    logic [PWM_BITS-1:0] r_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] r_inv;
    logic [PWM_BITS-1:0] duty_r;
    logic [PWM_BITS-1:0] duty_g;
    logic [PWM_BITS-1:0] duty_b;
    phase_t              phase_q;
    phase_t              phase_d;
    logic                tick;
    logic                ramp_end;

    assign tick     = en && (ps_q == PS_LAST);
    assign ramp_end = tick && (r_q == MAX);
    assign r_inv    = MAX - r_q;
    assign phase    = phase_q;

    always_ff @(posedge clk) begin
        if (!rst_n || restart)
            ps_q <= '0;
        else if (en)
            ps_q <= tick ? '0 : ps_q + 1'b1;
    end

    // The ramp wraps MAX -> 0 naturally, which coincides with the phase advance.
    always_ff @(posedge clk) begin
        if (!rst_n || restart)
            r_q <= '0;
        else if (tick)
            r_q <= r_q + 1'b1;
    end

    // The PWM counter ignores en and restart so the carrier never stalls.
    always_ff @(posedge clk) begin
        if (!rst_n)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            phase_q <= PH_RY;
        else
            phase_q <= phase_d;
    end

    always_comb begin
        phase_d = phase_q;
        if (restart)
            phase_d = PH_RY;
        else if (ramp_end)
            phase_d = next_phase(phase_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            phase_wrap <= 1'b0;
        else
            phase_wrap <= !restart && ramp_end && (phase_q == PH_MR);
    end

    // Each phase holds one channel full, one ramping and one dark, so colour is continuous.
    always_comb begin
        duty_r = '0;
        duty_g = '0;
        duty_b = '0;
        case (phase_q)
            PH_RY: begin duty_r = MAX;   duty_g = r_q;   end
            PH_YG: begin duty_r = r_inv; duty_g = MAX;   end
            PH_GC: begin duty_g = MAX;   duty_b = r_q;   end
            PH_CB: begin duty_g = r_inv; duty_b = MAX;   end
            PH_BM: begin duty_r = r_q;   duty_b = MAX;   end
            PH_MR: begin duty_r = MAX;   duty_b = r_inv; end
            default: ;
        endcase
    end

    rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_red (
        .clk(clk), .rst_n(rst_n), .en(en), .duty(duty_r), .pwm_cnt(pwm_cnt), .pin(RGB_R)
    );

    rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_green (
        .clk(clk), .rst_n(rst_n), .en(en), .duty(duty_g), .pwm_cnt(pwm_cnt), .pin(RGB_G)
    );

    rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_blue (
        .clk(clk), .rst_n(rst_n), .en(en), .duty(duty_b), .pwm_cnt(pwm_cnt), .pin(RGB_B)
    );

endmodule
